// File: rtl/dct_pkg.sv
// Shared widths, ROM geometry, error codes and frame-length decoding for the
// DCT pre-rotation stage.
package dct_pkg;

  localparam int DATA_W    = 18;
  localparam int COEF_W    = 16;
  localparam int OUT_W     = 22;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int FULL_W    = DATA_W + COEF_W + 1;
  localparam int SH        = FULL_W - OUT_W;
  localparam int ROM_DEPTH = 2048;
  localparam int ROM_AW    = 11;
  localparam int PTS_W     = 12;

  localparam logic [COEF_W-1:0] C_ONE = 16'd32767;

  typedef enum logic [1:0] {
    ERR_OK        = 2'b00,
    ERR_EARLY_EOP = 2'b01,
    ERR_OVERRUN   = 2'b10,
    ERR_BAD_PTS   = 2'b11
  } err_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] sh;
  } pts_info_t;

  // sh = log2(2048/N) so that k << sh indexes the 2048-entry quarter-wave table
  function automatic pts_info_t pts_info(input logic [PTS_W-1:0] n);
    pts_info_t r;
    r.legal = 1'b1;
    r.sh    = 4'd0;
    case (n)
      12'd2048: r.sh = 4'd0;
      12'd1024: r.sh = 4'd1;
      12'd512:  r.sh = 4'd2;
      12'd256:  r.sh = 4'd3;
      12'd128:  r.sh = 4'd4;
      12'd64:   r.sh = 4'd5;
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dct_twiddle_rom.sv
// Registered twiddle ROM: entry a holds {round(32767*cos(pi*a/4096)),
// round(32767*sin(pi*a/4096))}, elaborated from the formula.
module dct_twiddle_rom
  import dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [ROM_AW-1:0]     addr_i,
  output logic [2*COEF_W-1:0]   cs_o
);

  function automatic logic [2*COEF_W-1:0] entry(input int a);
    real ang;
    int  c;
    int  s;
    ang = 3.14159265358979323846 * real'(a) / 4096.0;
    c   = $rtoi(32767.0 * $cos(ang) + 0.5);
    s   = $rtoi(32767.0 * $sin(ang) + 0.5);
    return {COEF_W'(c), COEF_W'(s)};
  endfunction

  logic [2*COEF_W-1:0] rom [ROM_DEPTH];
  logic [2*COEF_W-1:0] cs_q;

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    localparam logic [2*COEF_W-1:0] ENTRY = entry(i);
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (en_i) cs_q <= rom[addr_i];
  end

  assign cs_o = cs_q;

endmodule

// File: rtl/dct_vecrot.sv
// DCT pre-rotation: X(k) * (C - jS), 4-stage stall-by-ready pipeline.
// Build option DCT_VECROT_ROUND_EN selects round-half-up instead of floor.
module dct_vecrot
  import dct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n_sync,
  input  logic                     sink_valid,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  output logic                     sink_ready,
  input  logic [1:0]               sink_error,
  input  logic signed [DATA_W-1:0] sink_real,
  input  logic signed [DATA_W-1:0] sink_imag,
  input  logic [PTS_W-1:0]         fftpts_in,
  output logic                     source_valid,
  output logic                     source_sop,
  output logic                     source_eop,
  input  logic                     source_ready,
  output logic [1:0]               source_error,
  output logic signed [OUT_W-1:0]  source_real,
  output logic signed [OUT_W-1:0]  source_imag,
  output logic [PTS_W-1:0]         fftpts_out
);

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [FULL_W-1:0] x);
    logic signed [FULL_W:0] t;
`ifdef DCT_VECROT_ROUND_EN
    t = $signed({x[FULL_W-1], x}) + $signed((FULL_W+1)'(1 << (SH-1)));
`else
    t = $signed({x[FULL_W-1], x});
`endif
    return t[SH +: OUT_W];
  endfunction

  logic en, acc;
  assign en         = source_ready;
  assign sink_ready = source_ready;
  assign acc        = sink_valid & source_ready;

  logic unused_err;
  assign unused_err = ^sink_error;

  logic [PTS_W-1:0]  n_q, n_d, n_cur;
  logic [ROM_AW-1:0] k_q, k_d, k_cur, addr_cur;
  logic              wrap_q, wrap_d, last;
  pts_info_t         info;
  err_e              err_cur;

  // wrap_q remembers that k = N-1 has been consumed, so a sop-less beat is an overrun
  always_comb begin
    n_cur    = sink_sop ? fftpts_in : n_q;
    info     = pts_info(n_cur);
    k_cur    = (sink_sop || wrap_q) ? '0 : k_q;
    last     = info.legal && ({1'b0, k_cur} == n_cur - 1'b1);
    addr_cur = k_cur << info.sh;
    if (!info.legal)             err_cur = ERR_BAD_PTS;
    else if (!sink_sop && wrap_q) err_cur = ERR_OVERRUN;
    else if (sink_eop && !last)  err_cur = ERR_EARLY_EOP;
    else                         err_cur = ERR_OK;
    n_d    = n_q;
    k_d    = k_q;
    wrap_d = wrap_q;
    if (acc) begin
      n_d    = n_cur;
      k_d    = k_cur + 1'b1;
      wrap_d = last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      n_q    <= '0;
      k_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      k_q    <= k_d;
      wrap_q <= wrap_d;
    end
  end

  logic                     vld_p0_q, sop_p0_q, eop_p0_q, bad_p0_q;
  logic                     vld_p1_q, sop_p1_q, eop_p1_q, bad_p1_q;
  logic                     vld_p2_q, sop_p2_q, eop_p2_q;
  err_e                     err_p0_q, err_p1_q, err_p2_q;
  logic [PTS_W-1:0]         n_p0_q, n_p1_q, n_p2_q;
  logic [ROM_AW-1:0]        addr_p0_q;
  logic signed [DATA_W-1:0] re_p0_q, im_p0_q, re_p1_q, im_p1_q;
  logic signed [PROD_W-1:0] ac_p2_q, bs_p2_q, bc_p2_q, as_p2_q;
  logic [2*COEF_W-1:0]      cs_p1;
  logic signed [COEF_W-1:0] c_s, s_s;

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      vld_p0_q <= 1'b0; sop_p0_q <= 1'b0; eop_p0_q <= 1'b0;
      vld_p1_q <= 1'b0; sop_p1_q <= 1'b0; eop_p1_q <= 1'b0;
      vld_p2_q <= 1'b0; sop_p2_q <= 1'b0; eop_p2_q <= 1'b0;
    end else if (en) begin
      vld_p0_q <= sink_valid;
      sop_p0_q <= sink_valid & sink_sop;
      eop_p0_q <= sink_valid & sink_eop;
      vld_p1_q <= vld_p0_q; sop_p1_q <= sop_p0_q; eop_p1_q <= eop_p0_q;
      vld_p2_q <= vld_p1_q; sop_p2_q <= sop_p1_q; eop_p2_q <= eop_p1_q;
    end
  end

  // S0: capture beat, frame length, error and ROM address
  always_ff @(posedge clk) begin
    if (en) begin
      re_p0_q   <= sink_real;
      im_p0_q   <= sink_imag;
      err_p0_q  <= err_cur;
      n_p0_q    <= n_cur;
      bad_p0_q  <= !info.legal;
      addr_p0_q <= addr_cur;
    end
  end

  // S1: ROM read, sideband follows
  dct_twiddle_rom u_rom (
    .clk    (clk),
    .en_i   (en),
    .addr_i (addr_p0_q),
    .cs_o   (cs_p1)
  );

  always_ff @(posedge clk) begin
    if (en) begin
      re_p1_q  <= re_p0_q;
      im_p1_q  <= im_p0_q;
      err_p1_q <= err_p0_q;
      n_p1_q   <= n_p0_q;
      bad_p1_q <= bad_p0_q;
    end
  end

  // S2: four products; an illegal frame length forces W = 1
  assign c_s = bad_p1_q ? $signed(C_ONE) : $signed(cs_p1[2*COEF_W-1:COEF_W]);
  assign s_s = bad_p1_q ? '0 : $signed(cs_p1[COEF_W-1:0]);

  always_ff @(posedge clk) begin
    if (en) begin
      ac_p2_q  <= PROD_W'(re_p1_q) * PROD_W'(c_s);
      bs_p2_q  <= PROD_W'(im_p1_q) * PROD_W'(s_s);
      bc_p2_q  <= PROD_W'(im_p1_q) * PROD_W'(c_s);
      as_p2_q  <= PROD_W'(re_p1_q) * PROD_W'(s_s);
      err_p2_q <= err_p1_q;
      n_p2_q   <= n_p1_q;
    end
  end

  // S3: sum, scale and output register
  logic signed [FULL_W-1:0] re_full, im_full;
  assign re_full = FULL_W'(ac_p2_q) + FULL_W'(bs_p2_q);
  assign im_full = FULL_W'(bc_p2_q) - FULL_W'(as_p2_q);

  logic                    vld_q, sop_q, eop_q;
  logic [1:0]              err_q;
  logic [PTS_W-1:0]        pts_q;
  logic signed [OUT_W-1:0] real_q, imag_q;

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      err_q  <= '0;
      pts_q  <= '0;
      real_q <= '0;
      imag_q <= '0;
    end else if (en) begin
      vld_q  <= vld_p2_q;
      sop_q  <= sop_p2_q;
      eop_q  <= eop_p2_q;
      err_q  <= err_p2_q;
      pts_q  <= n_p2_q;
      real_q <= scale(re_full);
      imag_q <= scale(im_full);
    end
  end

  assign source_valid = vld_q;
  assign source_sop   = sop_q;
  assign source_eop   = eop_q;
  assign source_error = err_q;
  assign fftpts_out   = pts_q;
  assign source_real  = real_q;
  assign source_imag  = imag_q;

endmodule

// File: doc/dct_vecrot.md
# dct_vecrot

Pre-rotation stage of the DCT datapath, placed between the FFT core output and the vector-rotation saturation stage. Multiplies each FFT output bin X(k) of a frame by the twiddle W(k) = cos(πk/2N) − j·sin(πk/2N), where N = fftpts of the frame. The result is produced at full 22-bit precision, and the following stage saturates it to 16 bits. The block is a streaming, 4-stage pipeline with stall-by-ready, and carries sop/eop/fftpts alongside the data.

## Interface
- wDataIn, 18, signed input width per component
- wTw, 16, signed twiddle width, Q1.15 format (+1.0 → 32767)
- wDataOut, 22, signed output width per component
- clk  in  1  clock; everything is rising-edge.
- rst_n_sync  in  1  reset; one clock, synchronous, active-low (fixed).
- sink_valid / sink_sop / sink_eop  in  1 each  input beat qualifiers
- sink_ready  out  1  equals source_ready (combinational)
- sink_error  in  2  ignored
- sink_real / sink_imag  in  wDataIn  input bin, two's complement
- fftpts_in  in  12  frame length N; sampled on the accepted sop beat
- source_valid / source_sop / source_eop  out  1 each  delayed qualifiers
- source_ready  in  1  downstream ready; also acts as the pipeline enable
- source_error  out  2  00 ok, 01 early eop, 10 overrun, 11 bad fftpts
- source_real / source_imag  out  wDataOut  rotated bin
- fftpts_out  out  12  N latched for the frame, aligned with the beat

## Operation
- Accept rule: a beat is accepted when sink_valid && source_ready.
- Index counter k (11 bit):
  - Cleared to 0 on an accepted sop beat and that beat uses k = 0.
  - Otherwise increments by 1 on each accepted beat.
  - After reset, k starts at 0 even without a sop.
- Frame length: N is latched from fftpts_in on an accepted sop.
  - Legal N is a power of two, 64..2048.
  - Shift sh = log2(2048/N) gives ROM address a = k << sh, so angle = πa/4096.
- Twiddle ROM: 2048 entries of {C[a], S[a]}, unsigned 15-bit values in a wTw container.
  - C[a] = round(32767·cos(πa/4096)), S[a] = round(32767·sin(πa/4096)).
- Arithmetic: input (a + jb) times twiddle (C − jS).
  - re = a·C + b·S, im = b·C − a·S.
  - Full precision is wDataIn + wTw + 1 = 35 bits.
  - The result is divided by 2^SH, where SH = wDataIn + wTw + 1 − wDataOut = 13, and kept as the low wDataOut bits.
  - No overflow is possible for legal operands, so no saturation is applied here.
- Errors are reported on the affected output beat:
  - 01: eop accepted with k ≠ N−1.
  - 10: beat accepted with k = N−1 already passed and no sop. In that case k wraps to 0 and the frame continues.
  - 11: N is illegal. The whole frame uses W = 1 (C = 32767, S = 0).
  - If more than one error applies, the higher code wins.
- Simultaneous eop and sop on one beat: treated as a 1-beat frame. k = 0 is used and error 01 applies unless N = 1, and N = 1 is illegal (11 wins).

## Timing
- Pipeline stages, each advancing only when source_ready = 1:
  - S0: register input, k, N, qualifiers and the ROM address.
  - S1: ROM read.
  - S2: four products.
  - S3: sum, round/shift, output register.
- Latency: 4 enabled clocks from accept to source_valid.
- Throughput: 1 beat per clock.
- source_ready = 0 freezes every pipeline register, the ROM output register and k. Outputs then hold their values.
- source_valid follows sink_valid delayed by 4 enabled clocks. Bubbles propagate as source_valid = 0 with sop/eop = 0.
- Reset: all pipeline valid/sop/eop are cleared, and source_real, source_imag, source_error and fftpts_out go to 0. k and N are cleared as well.
- The reset takes effect on the first rising edge with rst_n_sync = 0, including mid-frame. In-flight beats are discarded.

## Configuration
- DCT_VECROT_ROUND_EN defined: round half up by adding 2^(SH−1) before the arithmetic shift right by SH.
- DCT_VECROT_ROUND_EN undefined: truncate (floor) by a plain arithmetic shift right by SH.
- Latency and all other behaviour are identical in both builds.

## Structure
- Package dct_pkg contains:
  - width defaults and the derived SH;
  - ROM depth 2048 and address width 11;
  - error codes ERR_OK/ERR_EARLY_EOP/ERR_OVERRUN/ERR_BAD_PTS;
  - the function mapping N to sh and a legality flag.
- Sub-module dct_twiddle_rom: registered read, with a clock enable, address in, {C, S} out. It is generated from the formula above.

## Test plan
- N = 2048, every beat (1000, 0) → beat k=0 gives (4000, 0), because (1000·32767 + 4096) >> 13 = 4000. Beat k=2047 carries eop and error 00.
- N = 64, beat k = 32 with input (8192, 0) → ROM address 1024, C = S = 23170, output (23170, −23170).
- Backpressure: in an N = 64 frame, hold source_ready low for 3 cycles at k = 20 → outputs hold, no beats are lost or duplicated, and the k sequence at the output stays contiguous.
- Early eop: N = 64 with eop at k = 10 → that output beat has error 01. The next sop restarts at k = 0 with error 00.
- Illegal fftpts = 100: input (5, 7) → output (20, 28), since W = 1, and error 11 on every beat of the frame.
- Rounding: input (1, 0) at k = 0 → output 4 with DCT_VECROT_ROUND_EN, 3 without. Separately, assert reset mid-frame → all outputs are 0 one edge later.
